// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters (IF fetch, MEM load/store)
// and the off-core memory bus.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_ready;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              bus_req;
  logic              bus_we;
  logic [3:0]        bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              bus_err;
  logic              stallreq_if;
  logic              stallreq_mem;

  // Environment side: requesters and memory.
  modport master (
    output if_req, if_addr, flush, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    input  if_data, if_ready, mem_rdata, mem_ready, bus_req, bus_we, bus_sel,
           bus_addr, bus_wdata, bus_err, stallreq_if, stallreq_mem
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, flush, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    output if_data, if_ready, mem_rdata, mem_ready, bus_req, bus_we, bus_sel,
           bus_addr, bus_wdata, bus_err, stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and the MEM-stage port,
// sequencing each access through IDLE -> ACC -> DONE with an ack timeout.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave p
);
  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [7:0]        cnt;
  logic              discard;
  logic              bus_req_r;
  logic              bus_we_r;
  logic [3:0]        bus_sel_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wdata_r;
  logic [DATA_W-1:0] if_data_r;
  logic [DATA_W-1:0] mem_rdata_r;
  logic              if_ready_r;
  logic              mem_ready_r;
  logic              bus_err_r;
  logic              expired;

  // The last permitted bus cycle is the one where the counter sits at TIMEOUT_CYC-1.
  assign expired = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      discard     <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_sel_r   <= '0;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
      if_data_r   <= '0;
      mem_rdata_r <= '0;
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
      bus_err_r   <= 1'b0;
    end else begin
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
      bus_err_r   <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          discard <= 1'b0;
          // MEM holds the older instruction, so it wins a tie.
          if (p.mem_req) begin
            bus_req_r   <= 1'b1;
            bus_we_r    <= p.mem_we;
            bus_sel_r   <= p.mem_sel;
            bus_addr_r  <= p.mem_addr;
            bus_wdata_r <= p.mem_wdata;
            state       <= MEM_ACC;
          end else if (p.if_req && !p.flush) begin
            bus_req_r  <= 1'b1;
            bus_we_r   <= 1'b0;
            bus_sel_r  <= 4'hF;
            bus_addr_r <= p.if_addr;
            state      <= IF_ACC;
          end
        end
        MEM_ACC: begin
          if (p.bus_ack) begin
            bus_req_r   <= 1'b0;
            if (!bus_we_r) mem_rdata_r <= p.bus_rdata;
            mem_ready_r <= 1'b1;
            state       <= DONE;
          end else if (expired) begin
            bus_req_r   <= 1'b0;
            mem_rdata_r <= '0;
            mem_ready_r <= 1'b1;
            bus_err_r   <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        IF_ACC: begin
          if (p.bus_ack || expired) begin
            bus_req_r <= 1'b0;
            discard   <= 1'b0;
            // A flush seen at any point of the bus cycle, including its last one, kills the fetch.
            if (discard || p.flush) begin
              state <= IDLE;
            end else begin
              if_data_r  <= p.bus_ack ? p.bus_rdata : '0;
              if_ready_r <= 1'b1;
              bus_err_r  <= ~p.bus_ack;
              state      <= DONE;
            end
          end else begin
            cnt <= cnt + 8'd1;
            if (p.flush) discard <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign p.bus_req      = bus_req_r;
  assign p.bus_we       = bus_we_r;
  assign p.bus_sel      = bus_sel_r;
  assign p.bus_addr     = bus_addr_r;
  assign p.bus_wdata    = bus_wdata_r;
  assign p.bus_err      = bus_err_r;
  assign p.if_data      = if_data_r;
  assign p.if_ready     = if_ready_r;
  assign p.mem_rdata    = mem_rdata_r;
  assign p.mem_ready    = mem_ready_r;
  assign p.stallreq_if  = p.if_req & ~if_ready_r;
  assign p.stallreq_mem = p.mem_req & ~mem_ready_r;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory bus between instruction fetch (PC register address plus chip enable) and the MEM-stage load/store port.
- Sequences each bus transaction through a small FSM and returns fetched or loaded data.
- Raises stall requests to the pipeline stall controller until the owning requester is served.
- Sits between the pc_reg/IF stage, the MEM stage and the off-core memory bus.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT_CYC, 255, max cycles to wait for bus_ack before aborting with error (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request (driven from PC chip enable)
if_addr  in  ADDR_W  fetch address (PC)
if_data  out  DATA_W  fetched instruction, valid when if_ready=1
if_ready  out  1  one-cycle pulse: fetch complete
flush  in  1  branch/flush; discards an in-flight fetch
mem_req  in  1  MEM-stage access request
mem_we  in  1  1=store, 0=load
mem_sel  in  4  byte enables
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, valid when mem_ready=1
mem_ready  out  1  one-cycle pulse: data access complete
bus_req  out  1  bus cycle active
bus_we  out  1  bus write enable
bus_sel  out  4  bus byte enables
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_rdata  in  DATA_W  bus read data, valid with bus_ack
bus_ack  in  1  one-cycle completion from memory
bus_err  out  1  one-cycle pulse on timeout abort (with the ready pulse)
stallreq_if  out  1  fetch stall request to stall controller
stallreq_mem  out  1  MEM stall request to stall controller

Behaviour:
- Reset (rst=1 at edge): state=IDLE. bus_req, bus_we, if_ready, mem_ready and bus_err are 0. bus_sel, bus_addr, bus_wdata, if_data and mem_rdata are 0. Timeout counter and discard flag are cleared.
- Reset mid-transaction drops bus_req immediately. No ready pulse is issued. A bus_ack arriving afterwards is ignored.
- FSM states: IDLE, IF_ACC, MEM_ACC, DONE.
- IDLE arbitration:
  - mem_req=1: latch mem_we/sel/addr/wdata onto the bus, bus_req<=1, go to MEM_ACC.
  - else if_req=1 and flush=0: bus_we<=0, bus_sel<=4'hF, bus_addr<=if_addr, bus_req<=1, go to IF_ACC.
  - else stay in IDLE.
- Priority: the MEM stage always wins simultaneous requests, because it holds the older instruction.
- ACC states: bus outputs are held stable until bus_ack. Counter increments each cycle.
- On bus_ack:
  - bus_req<=0.
  - Load or fetch: capture bus_rdata into mem_rdata or if_data.
  - Store: mem_rdata is left unchanged.
  - Assert the matching ready pulse and go to DONE.
- Timeout: counter reaches TIMEOUT_CYC with no bus_ack. Then bus_req<=0, the data output is set to 0, the ready pulse and bus_err pulse fire, and the FSM goes to DONE.
- DONE: lasts exactly one cycle; ready is high; no arbitration; next state IDLE. This suppresses re-issue of a request still held during its ready cycle.
- Latency:
  - Request sampled in IDLE at edge N: bus_req=1 from cycle N+1.
  - bus_ack in cycle K: ready=1 in cycle K+1.
  - Next arbitration at edge K+2.
  - Minimum 3 cycles per access with zero-wait memory (ack in the first bus cycle).
- Flush:
  - flush=1 in IF_ACC sets the discard flag. The bus cycle still completes.
  - On ack or timeout with discard set: go straight to IDLE, no if_ready, if_data unchanged.
  - flush in IDLE blocks fetch issue for that cycle only.
  - flush has no effect on MEM_ACC.
- Stall outputs (combinational from registered state):
  - stallreq_if = if_req & ~if_ready.
  - stallreq_mem = mem_req & ~mem_ready.
- Requesters hold req/addr stable until their ready pulse.
- bus_ack outside an ACC state is ignored.

Test Plan:
- Fetch, zero-wait: if_req=1, if_addr=0x0000_0004; bus_ack with rdata=0x3401_0020 in the first bus cycle. Required: bus_req high one cycle, addr 0x4; if_ready pulse with if_data=0x3401_0020 two cycles after issue; stallreq_if low in that cycle.
- Contention: if_req and mem_req (load, addr 0x100) rise together; memory acks after 2 wait cycles. Required: MEM served first with mem_ready and mem_rdata; fetch issued only after DONE then IDLE; stallreq_if stays high throughout.
- Store: mem_we=1, sel=4'b0011, wdata=0xDEAD_BEEF. Required: bus_we=1, bus_sel=0011, bus_wdata held until ack; mem_ready pulses; mem_rdata unchanged.
- Flush: flush pulse during IF_ACC for addr 0x8; ack 3 cycles later. Required: no if_ready; return to IDLE; a new fetch at branch target 0x40 issues next cycle.
- Timeout: no ack, TIMEOUT_CYC=4. Required: bus_req drops after 4 cycles; mem_ready, bus_err and mem_rdata=0 pulse together; a late ack is ignored.
- Reset in MEM_ACC: rst=1 for one cycle. Required: bus_req=0 next cycle; all outputs at reset values; no ready pulse.
